// File: rtl/key_event_fifo.sv
// De-duplicating key event FIFO: buffers {broken, code} events from the scancode
// converter and drops typematic repeat makes. Output is first-word-fall-through.
module key_event_fifo #(
    parameter int DEPTH         = 8,
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               key_data,
    input  logic                     key_broken,
    input  logic                     key_data_stb,
    output logic [8:0]               ev_data,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic       broken;
        logic [7:0] code;
    } key_ev_t;

    key_ev_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    held_code;
    logic          held_valid;

    logic    full, filtered, cand, push, pop, drop;
    key_ev_t wr_ev;

    assign wr_ev    = '{broken: key_broken, code: key_data};
    assign ev_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = ev_valid && ev_ready;

    // A make of the still-held key is a typematic repeat.
    assign filtered = FILTER_REPEAT && !key_broken && held_valid && (key_data == held_code);
    assign cand     = key_data_stb && !filtered;
    // A pop in the same cycle frees the slot the full FIFO needs.
    assign push     = cand && (!full || pop);
    assign drop     = cand && full && !pop;

    assign ev_data  = ev_valid ? mem[rd_ptr] : 9'h000;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            held_code  <= 8'h00;
            held_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;

            // Filter state follows only events that actually land in the FIFO.
            if (FILTER_REPEAT && push) begin
                if (!key_broken) begin
                    held_code  <= key_data;
                    held_valid <= 1'b1;
                end else if (key_data == held_code) begin
                    held_valid <= 1'b0;
                end
            end
        end
    end
endmodule
